// File: rtl/dense_pkg.sv
// Shared types and sizing helpers for the dense-layer sequencer.
package dense_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_e;

    localparam int N_DEF     = 4;
    localparam int WIDTH_DEF = 8;
    localparam int M_DEF     = 4;

    function automatic int sumw(input int width);
        return 2 * width + 2;
    endfunction

    function automatic int idxw(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    function automatic int sat_hi(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int sat_lo(input int width, input int relu);
        return (relu != 0) ? 0 : -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/dense_seq_act_sat.sv
// Requantize a MAC sum: arithmetic shift, optional ReLU floor, saturate to WIDTH.
module act_sat
    import dense_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic signed [2*WIDTH+1:0] sum_i,
    output logic        [WIDTH-1:0]   y_o
);

    localparam int SW = sumw(WIDTH);
    localparam logic signed [SW-1:0] HI = SW'(sat_hi(WIDTH));
    localparam logic signed [SW-1:0] LO = SW'(sat_lo(WIDTH, RELU));

    logic signed [SW-1:0] t;

    always_comb begin
        t = sum_i >>> SHIFT;
        if (t > HI) begin
            y_o = HI[WIDTH-1:0];
        end else if (t < LO) begin
            y_o = LO[WIDTH-1:0];
        end else begin
            y_o = t[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/dense_seq.sv
// Dense-layer sequencer: latches one bundle, runs M MAC jobs, returns M results.
module dense_seq
    import dense_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int M     = M_DEF,
    parameter int SHIFT = 0,
    parameter int RELU  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N*WIDTH-1:0]       x_in,
    input  logic [M*N*WIDTH-1:0]     w_in,
    input  logic [M*WIDTH-1:0]       b_in,
    output logic                     mac_start,
    output logic [N*WIDTH-1:0]       mac_x,
    output logic [N*WIDTH-1:0]       mac_w,
    output logic [WIDTH-1:0]         mac_b,
    input  logic                     mac_done,
    input  logic signed [2*WIDTH+1:0] mac_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [M*WIDTH-1:0]       y_out
);

    localparam int IW = idxw(M);
    localparam int RW = N * WIDTH;

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [RW-1:0]        x_q, x_d;
    logic [M*RW-1:0]      w_q, w_d;
    logic [M*WIDTH-1:0]   b_q, b_d;
    logic [M*WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]     act_y;

    act_sat #(
        .WIDTH(WIDTH),
        .SHIFT(SHIFT),
        .RELU (RELU)
    ) u_act (
        .sum_i(mac_sum),
        .y_o  (act_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            w_q     <= w_d;
            b_q     <= b_d;
            y_q     <= y_d;
        end
    end

    // mac_done only counts in WAIT; a level left high from the last job is ignored
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    w_d     = w_in;
                    b_d     = b_in;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (mac_done) begin
                    for (int k = 0; k < M; k++) begin
                        if (idx_q == IW'(k)) y_d[k*WIDTH +: WIDTH] = act_y;
                    end
                    if (idx_q == IW'(M - 1)) begin
                        state_d = OUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = START;
                    end
                end
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        mac_start = (state_q == START);
        out_valid = (state_q == OUT);
        y_out     = y_q;
        mac_x     = x_q;
        mac_w     = '0;
        mac_b     = '0;
        for (int k = 0; k < M; k++) begin
            if (idx_q == IW'(k)) begin
                mac_w = w_q[k*RW +: RW];
                mac_b = b_q[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: doc/dense_seq.md
# dense_seq

Dense-layer sequencer that drives an external sequential multiply-accumulate unit through its start/done handshake. It accepts one input vector, a full M×N weight matrix and M biases on a valid/ready port. It then issues M MAC operations, one per output neuron, and applies requantize, optional ReLU and saturation to each result. The M packed outputs are returned on a second valid/ready port. It sits between the layer buffer and the MAC, acting as the MAC's initiator.

## Interface
- N, 4, elements per dot product (must match the MAC's N)
- WIDTH, 8, signed element width
- M, 4, number of output neurons
- SHIFT, 0, arithmetic right shift applied to each MAC sum before saturation (0..WIDTH+1)
- RELU, 1, 1 = clamp negatives to 0; 0 = signed output
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  input bundle valid
- in_ready  output  1  high only in IDLE
- x_in  input  N*WIDTH  signed input vector, element i at [i*WIDTH +: WIDTH]
- w_in  input  M*N*WIDTH  weights, row k at [k*N*WIDTH +: N*WIDTH]
- b_in  input  M*WIDTH  biases, bias k at [k*WIDTH +: WIDTH]
- mac_start  output  1  one-cycle start pulse to MAC
- mac_x  output  N*WIDTH  latched x to MAC
- mac_w  output  N*WIDTH  latched weight row idx
- mac_b  output  WIDTH  latched bias idx
- mac_done  input  1  MAC done level
- mac_sum  input  2*WIDTH+2  signed MAC result
- out_valid  output  1  result bundle valid
- out_ready  input  1  downstream accepts
- y_out  output  M*WIDTH  signed results, neuron k at [k*WIDTH +: WIDTH]

## Operation
- States: IDLE, START, WAIT, OUT.
- IDLE: in_ready=1. On in_valid, latch x_in/w_in/b_in, set idx=0 and go to START.
- START: mac_start=1 for exactly this cycle, then go to WAIT.
- WAIT: mac_start=0. When mac_done=1, compute act(mac_sum) and write it to y slot idx.
  - If idx==M-1, go to OUT.
  - Otherwise increment idx and go to START.
- OUT: out_valid=1 and y_out is held stable. On out_ready, go to IDLE. out_valid and y_out must not change while out_ready=0.
- mac_done is ignored in every state except WAIT. A stale done level in IDLE/START/OUT has no effect.
- mac_x/mac_w/mac_b are driven from the latched registers indexed by idx. They are stable from START until done is seen, because the MAC reads them across N cycles.
- act(s): t = s >>> SHIFT (arithmetic, truncating). Lower bound lo = 0 if RELU else -2^(WIDTH-1); upper bound hi = 2^(WIDTH-1)-1. y = min(max(t, lo), hi). The result is taken as the low WIDTH bits.
- y slots not yet written in a transaction keep their previous values. All M slots are written before OUT.
- Reset (rst_n=0 on any edge, including mid-transaction): state=IDLE, idx=0, in_ready=1 after reset, mac_start=0, out_valid=0, y_out=0, latched x/w/b=0. An in-flight MAC result is discarded.

## Timing
- Input handshake at edge t. START for neuron k occupies cycle t+1+k(N+2).
- The MAC raises done N cycles after sampling start, so WAIT sees done in cycle t+1+k(N+2)+N+1.
- out_valid first high in cycle t+M(N+2)+1. With defaults this is 25 cycles after the input handshake.
- Minimum spacing between input handshakes is M(N+2)+2 cycles. This is 1 cycle in OUT with out_ready=1, plus 1 cycle in IDLE.
- No combinational path from in_valid/out_ready/mac_done to any output. in_ready, mac_start and out_valid are decoded from state only.

## Structure
- Package dense_pkg holds:
  - state enum (IDLE, START, WAIT, OUT)
  - localparams SUMW = 2*WIDTH+2 and IDXW = max(1, $clog2(M))
  - saturation bound constants
- One natural sub-module: act_sat. It is purely combinational: SUMW-bit signed in, SHIFT/RELU parameters, WIDTH-bit out. It is instantiated once, on mac_sum.
- The MAC itself is external. The bench instantiates the team's MAC (with reset driven by ~rst_n) alongside dense_seq.

## Test plan
- Defaults, RELU=1, x=[1,2,3,4]. Rows w0=[1,1,1,1] b0=0, w1=[-1,-1,-1,-1] b1=0, w2=[10,10,10,10] b2=27, w3=[127,127,127,127] b3=0. Required y=[10,0,127,127], with out_valid exactly 25 cycles after the input handshake.
- RELU=0, same x. Rows w0=[-1,-1,-1,-1] b0=0, w1=[-128,-128,-128,-128] b1=0, w2=[10,10,10,10] b2=28, w3=0 b3=-5. Required y=[-10 (0xF6), -128, 127, -5].
- SHIFT=2, RELU=0, x=[1,2,3,4]. Rows w0=[1,1,1,1] b0=1 (sum 11), w1=[-1,-1,-1,-1] b1=-1 (sum -11), w2=w3=0, b2=b3=0. Required y=[2,-3,0,0].
- Backpressure: hold out_ready=0 for 5 cycles in OUT with in_valid=1. y_out and out_valid must stay stable, with in_ready=0 and mac_start=0 throughout. After out_ready=1, in_ready rises 1 cycle later and the next bundle is accepted.
- Reset mid-WAIT for neuron 2: the next cycle shows out_valid=0, y_out=0, mac_start=0 and in_ready=1. A fresh transaction then completes with correct values and 25-cycle latency.
- Count mac_start pulses per transaction: exactly M, each one cycle wide, spaced N+2 cycles apart. mac_w must equal row idx throughout each WAIT.
